// File: rtl/tx_stage_ser8.sv
// tx_stage_ser8: output stage behind the 4-operand ALU.
// Takes one {carry, 10-bit result} per valid/ready handshake and emits it
// as a two-beat byte frame. The host paces each beat with a rising edge on
// ack_in, which is optionally passed through a two-flop synchroniser.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no frame held; res_ready high, ack edges ignored
// BEAT0 | low byte res[7:0] on dout, waiting for ack_rise
// BEAT1 | high byte {frame_cnt, 0, carry, res[9:8]} on dout, waiting for ack_rise

module tx_stage_ser8 #(
   parameter bit ACK_SYNC = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [9:0] res_in,
   input  logic       carry_in,
   input  logic       res_valid,
   output logic       res_ready,
   input  logic       ack_in,
   output logic [7:0] dout,
   output logic       dout_valid,
   output logic       dout_phase,
   output logic [3:0] frame_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BEAT0 = 2'd1,
      BEAT1 = 2'd2
   } state_t;

   state_t      state;
   logic [10:0] hold;
   logic        ack_s;
   logic        ack_prev;
   logic        ack_rise;

   generate
      if (ACK_SYNC) begin : g_ack_sync
         logic ack_meta;
         logic ack_sync;

         // Two-flop synchroniser for the asynchronous host acknowledge.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               ack_meta <= 1'b0;
               ack_sync <= 1'b0;
            end else begin
               ack_meta <= ack_in;
               ack_sync <= ack_meta;
            end
         end

         assign ack_s = ack_sync;
      end else begin : g_ack_direct
         assign ack_s = ack_in;
      end
   endgenerate

   // Delayed copy of the acknowledge so a held-high ack yields one edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack_prev <= 1'b0;
      end else begin
         ack_prev <= ack_s;
      end
   end

   assign ack_rise  = ack_s & ~ack_prev;

   // No pass-through: a result is only taken while the stage is empty.
   assign res_ready = (state == IDLE);

   // Frame sequencer with registered output byte, flags and frame counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         hold       <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
         dout_phase <= 1'b0;
         frame_cnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (res_valid) begin
                  hold       <= {carry_in, res_in};
                  dout       <= res_in[7:0];
                  dout_valid <= 1'b1;
                  dout_phase <= 1'b0;
                  state      <= BEAT0;
               end
            end
            BEAT0: begin
               if (ack_rise) begin
                  dout       <= {frame_cnt, 1'b0, hold[10:8]};
                  dout_phase <= 1'b1;
                  state      <= BEAT1;
               end else begin
                  // Re-present the captured low byte; it already sits on dout.
                  dout <= hold[7:0];
               end
            end
            BEAT1: begin
               if (ack_rise) begin
                  dout       <= '0;
                  dout_valid <= 1'b0;
                  dout_phase <= 1'b0;
                  frame_cnt  <= frame_cnt + 4'd1;
                  state      <= IDLE;
               end
            end
            default: begin
               dout       <= '0;
               dout_valid <= 1'b0;
               dout_phase <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end

endmodule
